// File: rtl/csa_resolve_adder.sv
// rtl/csa_resolve_adder.sv - multi-cycle chunked carry-propagate resolver for a carry-save (sum, carry) pair; optional ovf via CSA_RESOLVE_OVF_EN
module csa_resolve_adder #(
    parameter int N     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] sum_in,
    input  logic [N:0]   carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+1:0] result
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NCHUNK = N / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sum_q, sum_d;
    logic [N:0]     car_q, car_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           c_q, c_d;
    logic [N+1:0]   result_q, result_d;
`ifdef CSA_RESOLVE_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic [1:0]       top_bits;
    logic             last_chunk;

    // Pick the operand slice addressed by the chunk counter and add it with the registered carry.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                chunk_a = sum_q[i*CHUNK +: CHUNK];
                chunk_b = car_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, c_q};
        // carry_in[N] plus the final chunk's carry-out forms the two extra result bits
        top_bits   = {1'b0, car_q[N]} + {1'b0, chunk_sum[CHUNK]};
        last_chunk = (cnt_q == CW'(NCHUNK - 1));
    end

    // Next-state logic: capture in IDLE, one chunk per cycle in BUSY, hold in DONE until accepted.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        car_d    = car_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
`ifdef CSA_RESOLVE_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d   = sum_in;
                    car_d   = carry_in;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // chunks not yet reached keep whatever they held before
                for (int i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                c_d   = chunk_sum[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (last_chunk) begin
                    result_d[N+1:N] = top_bits;
`ifdef CSA_RESOLVE_OVF_EN
                    ovf_d           = |top_bits;
`endif
                    state_d         = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            car_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
`ifdef CSA_RESOLVE_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            car_q    <= car_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
`ifdef CSA_RESOLVE_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Handshake outputs depend on state only, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
`ifdef CSA_RESOLVE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
